// File: rtl/tx_arbiter_pkg.sv
// Shared types and helpers for the two-channel transmit arbiter.
//   arb_state_t : 3-bit FSM state codes (ARB_IDLE .. ARB_WAIT_DONE)
//   chan_t      : channel identifier, CH_A = 0, CH_B = 1
//   bits_for()  : register width needed to hold values 0..max_val
package tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_LOAD      = 3'd1,
    ARB_CAPTURE   = 3'd2,
    ARB_START     = 3'd3,
    ARB_WAIT_ACK  = 3'd4,
    ARB_WAIT_DONE = 3'd5
  } arb_state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin channel choice with a burst limit.
// The current owner keeps the line while it has data and has sent fewer
// than BURST consecutive bytes; otherwise a non-empty other channel takes
// over. If only the owner has data it keeps the line and its count restarts.
//   empty_a, empty_b : FIFO empty flags
//   owner            : channel that sent the previous byte
//   burst_cnt        : consecutive bytes already sent by owner
//   chosen           : channel to serve next
//   burst_cnt_next   : burst count after serving chosen (1..BURST)
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic             empty_a,
  input  logic             empty_b,
  input  chan_t            owner,
  input  logic [CNT_W-1:0] burst_cnt,
  output chan_t            chosen,
  output logic [CNT_W-1:0] burst_cnt_next
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic owner_ready;
  logic other_ready;

  assign owner_ready = (owner == CH_A) ? !empty_a : !empty_b;
  assign other_ready = (owner == CH_A) ? !empty_b : !empty_a;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latch).
    chosen         = owner;
    burst_cnt_next = CNT_ONE;
    if (owner_ready && (burst_cnt < BURST_MAX)) begin
      burst_cnt_next = burst_cnt + CNT_ONE;
    end else if (other_ready) begin
      chosen = chan_t'(~owner);
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one serial transmitter between two byte
// FIFOs. One byte per transaction: pick a channel, pulse its read enable,
// capture the FIFO data, pulse start_tr, then wait for the transmitter to
// raise and drop busy_tr. A transmitter that never raises busy_tr within
// ACK_TO cycles gets err_ack and the byte is dropped.
//   clk, rst          : clock, synchronous active-high reset
//   empty_a/b         : FIFO empty flags
//   re_a/b            : FIFO read enables (one-cycle pulses, never together)
//   data_a/b          : FIFO read data, valid the cycle after re
//   busy_tr           : transmitter busy
//   start_tr          : transmitter start pulse
//   data_tr           : byte to transmit (held until the next capture)
//   grant             : channel of the byte in flight (0=A, 1=B)
//   err_ack           : one-cycle pulse on acknowledge timeout
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int ACK_TO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty_a,
  output logic              re_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              empty_b,
  output logic              re_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              busy_tr,
  output logic              start_tr,
  output logic [DATA_W-1:0] data_tr,
  output logic              grant,
  output logic              err_ack
);

  localparam int CNT_W = bits_for(BURST);
  localparam int ACK_W = bits_for(ACK_TO);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);
  localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);

  arb_state_t       state;
  chan_t            owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [ACK_W-1:0] ack_cnt;
  chan_t            chosen;
  logic [CNT_W-1:0] burst_cnt_next;

  rr_pick #(
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) u_pick (
    .empty_a        (empty_a),
    .empty_b        (empty_b),
    .owner          (owner),
    .burst_cnt      (burst_cnt),
    .chosen         (chosen),
    .burst_cnt_next (burst_cnt_next)
  );

  // owner is updated only at the IDLE->LOAD decision, so it is exactly the
  // channel of the byte in flight and holds until the next LOAD.
  assign grant = owner;

  // Outputs are registered on the transition into the state that owns them:
  // re_x is high during LOAD, start_tr during START.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= CH_A;
      burst_cnt <= '0;
      ack_cnt   <= '0;
      data_tr   <= '0;
      re_a      <= 1'b0;
      re_b      <= 1'b0;
      start_tr  <= 1'b0;
      err_ack   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      re_a     <= 1'b0;
      re_b     <= 1'b0;
      start_tr <= 1'b0;
      err_ack  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (!busy_tr && (!empty_a || !empty_b)) begin
            owner     <= chosen;
            burst_cnt <= burst_cnt_next;
            re_a      <= (chosen == CH_A);
            re_b      <= (chosen == CH_B);
            state     <= ARB_LOAD;
          end
        end
        ARB_LOAD: begin
          state <= ARB_CAPTURE;
        end
        ARB_CAPTURE: begin
          data_tr  <= (owner == CH_A) ? data_a : data_b;
          start_tr <= 1'b1;
          state    <= ARB_START;
        end
        ARB_START: begin
          ack_cnt <= '0;
          state   <= ARB_WAIT_ACK;
        end
        ARB_WAIT_ACK: begin
          if (busy_tr) begin
            state <= ARB_WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            // ACK_TO-th cycle without busy_tr: give up on this byte.
            err_ack <= 1'b1;
            state   <= ARB_IDLE;
          end else begin
            ack_cnt <= ack_cnt + ACK_ONE;
          end
        end
        ARB_WAIT_DONE: begin
          if (!busy_tr) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
